// File: rtl/clock_pkg.sv
// Shared definitions for the clock user-interface blocks.
//   - field index constants (sec/min/hour) and field count
//   - mode-state enumeration for the RUN/SET state machine
//   - sel_field display encodings
//   - helpers that map a mode state to its field one-hot, its display
//     encoding and the state a mode press advances to
package clock_pkg;

    localparam int NUM_FIELDS = 3;
    localparam int FIELD_SEC  = 0;
    localparam int FIELD_MIN  = 1;
    localparam int FIELD_HOUR = 2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } mode_state_e;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_SEC  = 2'd1;
    localparam logic [1:0] SEL_MIN  = 2'd2;
    localparam logic [1:0] SEL_HOUR = 2'd3;

    // One-hot of the field being edited; all zero in RUN.
    function automatic logic [NUM_FIELDS-1:0] field_onehot(input mode_state_e s);
        logic [NUM_FIELDS-1:0] oh;
        oh = '0;
        case (s)
            SET_HOUR: oh[FIELD_HOUR] = 1'b1;
            SET_MIN:  oh[FIELD_MIN]  = 1'b1;
            SET_SEC:  oh[FIELD_SEC]  = 1'b1;
            default:  oh = '0;
        endcase
        return oh;
    endfunction

    function automatic logic [1:0] sel_encode(input mode_state_e s);
        logic [1:0] sel;
        case (s)
            SET_HOUR: sel = SEL_HOUR;
            SET_MIN:  sel = SEL_MIN;
            SET_SEC:  sel = SEL_SEC;
            default:  sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    // Mode-press ring: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
    function automatic mode_state_e next_mode(input mode_state_e s);
        mode_state_e n;
        case (s)
            RUN:      n = SET_HOUR;
            SET_HOUR: n = SET_MIN;
            SET_MIN:  n = SET_SEC;
            default:  n = RUN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a debounce counter for one raw button.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : raw button level, asynchronous to clk
//   level      : debounced level
//   rise       : one-cycle pulse, registered together with a 0->1 level change
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    // The counter measures how long the synchronized level has disagreed
    // with the accepted level; any agreement restarts the measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            rise    <= 1'b0;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync_q2;
                rise  <= sync_q2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Button user interface for the clock's time-setting mode.
// Debounces mode/up/down, runs the RUN/SET_HOUR/SET_MIN/SET_SEC machine and
// produces per-field set/freeze levels plus single-cycle inc/dec pulses with
// hold-to-auto-repeat, an idle timeout back to RUN and a display blink.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   btn_mode, btn_up, btn_down : raw active-high buttons
//   ctrl_set[2:0]              : one-hot set enable of the edited field
//   inc[2:0], dec[2:0]         : one-cycle step pulses on the edited field
//   freeze[2:0]                : hold on every field not being edited
//   sel_field[1:0]             : 0 none, 1 sec, 2 min, 3 hour
//   blink                      : display blink while editing, 0 in RUN
// All outputs are registered.
import clock_pkg::*;

module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_RATE     = 100,
    parameter int TIMEOUT         = 5000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn_mode,
    input  logic                  btn_up,
    input  logic                  btn_down,
    output logic [NUM_FIELDS-1:0] ctrl_set,
    output logic [NUM_FIELDS-1:0] inc,
    output logic [NUM_FIELDS-1:0] dec,
    output logic [NUM_FIELDS-1:0] freeze,
    output logic [1:0]            sel_field,
    output logic                  blink
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam int TO_W    = $clog2(TIMEOUT + 1);
    localparam int BL_W    = $clog2(REPEAT_RATE + 1);

    logic mode_lvl_unused, mode_rise;
    logic up_lvl, up_rise;
    logic dn_lvl, dn_rise;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(clk), .rst_n(rst_n), .raw(btn_mode), .level(mode_lvl_unused), .rise(mode_rise));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .rst_n(rst_n), .raw(btn_up), .level(up_lvl), .rise(up_rise));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(clk), .rst_n(rst_n), .raw(btn_down), .level(dn_lvl), .rise(dn_rise));

    mode_state_e      state_q, state_d;
    logic             armed_q, armed_d;        // a press happened; holding it may repeat
    logic             rep_up_q, rep_up_d;      // direction of the armed button
    logic             rep_first_q, rep_first_d; // still waiting for the first repeat
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [BL_W-1:0]  bl_cnt_q;
    logic             pulse_up, pulse_dn;
    logic [REP_W-1:0] rep_limit;

    assign rep_limit = rep_first_q ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_RATE - 1);

    // Priority: mode press, then timeout, then up/down. Pulses are only
    // produced in branches that keep the state, so they never coincide with
    // a state change, and every state change disarms repeat.
    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        rep_up_d    = rep_up_q;
        rep_first_d = rep_first_q;
        rep_cnt_d   = rep_cnt_q;
        to_cnt_d    = to_cnt_q;
        pulse_up    = 1'b0;
        pulse_dn    = 1'b0;

        if (state_q == RUN || mode_rise || to_cnt_q == TO_W'(TIMEOUT)) begin
            armed_d   = 1'b0;
            rep_cnt_d = '0;
            to_cnt_d  = '0;
            if (mode_rise) begin
                state_d = next_mode(state_q);
            end else if (state_q != RUN) begin
                state_d = RUN;
            end
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (up_lvl && dn_lvl) begin
                // Conflicting buttons: stay quiet until both are released
                // and one is pressed again.
                armed_d   = 1'b0;
                rep_cnt_d = '0;
                if (up_rise || dn_rise) begin
                    to_cnt_d = '0;
                end
            end else if (up_rise || dn_rise) begin
                pulse_up    = up_rise;
                pulse_dn    = dn_rise;
                armed_d     = 1'b1;
                rep_up_d    = up_rise;
                rep_first_d = 1'b1;
                rep_cnt_d   = '0;
                to_cnt_d    = '0;
            end else if (armed_q && (rep_up_q ? up_lvl : dn_lvl)) begin
                if (rep_cnt_q == rep_limit) begin
                    pulse_up    = rep_up_q;
                    pulse_dn    = !rep_up_q;
                    rep_first_d = 1'b0;
                    rep_cnt_d   = '0;
                    to_cnt_d    = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
            end else begin
                armed_d   = 1'b0;
                rep_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            armed_q     <= 1'b0;
            rep_up_q    <= 1'b0;
            rep_first_q <= 1'b0;
            rep_cnt_q   <= '0;
            to_cnt_q    <= '0;
            bl_cnt_q    <= '0;
            ctrl_set    <= '0;
            inc         <= '0;
            dec         <= '0;
            freeze      <= '0;
            sel_field   <= SEL_NONE;
            blink       <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            rep_up_q    <= rep_up_d;
            rep_first_q <= rep_first_d;
            rep_cnt_q   <= rep_cnt_d;
            to_cnt_q    <= to_cnt_d;
            // Field outputs follow the next state so they switch together
            // with the state register.
            ctrl_set    <= field_onehot(state_d);
            freeze      <= (state_d == RUN) ? '0 : ~field_onehot(state_d);
            sel_field   <= sel_encode(state_d);
            inc         <= pulse_up ? field_onehot(state_q) : '0;
            dec         <= pulse_dn ? field_onehot(state_q) : '0;
            // Blink phase restarts on entry to editing and is forced low in RUN.
            if (state_d == RUN || state_q == RUN) begin
                bl_cnt_q <= '0;
                blink    <= 1'b0;
            end else if (bl_cnt_q == BL_W'(REPEAT_RATE - 1)) begin
                bl_cnt_q <= '0;
                blink    <= ~blink;
            end else begin
                bl_cnt_q <= bl_cnt_q + BL_W'(1);
            end
        end
    end

endmodule
